fifo_req_gen: RTL
=================

# fifo_req_gen

Upstream request generator for the push-button FIFO. It conditions the raw write and read push-buttons and the data switches into clean, single-cycle `wr_pulse`/`rd_pulse` strobes, plus a registered `wr_data` word aligned with each write strobe. It replaces the separate per-button debounce and one-shot units ahead of the FIFO. It guarantees the FIFO never sees two strobes in the same cycle.

## Interface
Parameters:
- `B`, 8: data width, matches FIFO data width.
- `DB_CYC`, 1000: consecutive stable samples required to accept a press or a release. Must be ≥ 2.
- `CNT_W`, 20: width of the debounce and repeat counters. Must hold `max(DB_CYC, REPEAT_CYC)`.
- `REPEAT_CYC`, 4000: auto-repeat period in cycles. Used only with `AUTOREPEAT_EN`.

Ports:
- `clk`, in, 1: system clock. All logic on the rising edge.
- `clr`, in, 1: reset, synchronous, active-high.
- `button_wrd`, in, 1: raw write button. Asynchronous and bouncy. High = pressed.
- `button_red`, in, 1: raw read button. Asynchronous and bouncy. High = pressed.
- `sw_data`, in, B: raw data switches, quasi-static.
- `wr_pulse`, out, 1: one-cycle write strobe to the FIFO.
- `rd_pulse`, out, 1: one-cycle read strobe to the FIFO.
- `wr_data`, out, B: data word captured with the latest `wr_pulse`.
- `wr_held`, out, 1: write button debounced level (HELD or RELEASING).
- `rd_held`, out, 1: read button debounced level (HELD or RELEASING).

## Operation
- Each button passes through a 2-flop synchronizer, then a per-channel FSM with a `CNT_W` counter.
- Per-channel FSM states and transitions:
  - IDLE → ARMING when the synchronized input is 1. Counter = 0.
  - ARMING: the counter increments while the input is 1. Input 0 → IDLE, counter cleared. When the counter reaches DB_CYC−1 with the input still 1 → HELD and a press event is emitted.
  - HELD: input 0 → RELEASING, counter = 0.
  - RELEASING: the counter increments while the input is 0. Input 1 → HELD, with no new event. When the counter reaches DB_CYC−1 → IDLE.
- `wr_held`/`rd_held` = 1 in HELD and RELEASING.
- Write press event: `wr_pulse` = 1 for exactly one cycle. `wr_data` loads `sw_data` (through a 1-flop register stage) at the same edge. `wr_data` holds until the next write event.
- Read press event: `rd_pulse` = 1 for one cycle.
- Simultaneous write and read events: write wins. The read is latched in `rd_pend` and `rd_pulse` asserts on the following cycle. DB_CYC ≥ 2 ensures no second read event can arrive while a read is pending.
- `wr_pulse` and `rd_pulse` are never high in the same cycle.
- Reset values: `wr_pulse` = 0, `rd_pulse` = 0, `wr_data` = 0, `wr_held` = 0, `rd_held` = 0. Both FSMs in IDLE, counters = 0, synchronizers = 0, `rd_pend` = 0.
- Reset mid-operation: all of the above is restored at the edge where `clr` = 1, and any pending read is discarded. A button still held when `clr` falls is treated as a new press and produces a pulse after full debounce.

## Timing
- Raw input stable high before edge N: synchronized value visible after edge N+1, ARMING entered at edge N+2.
- Pulse asserted in the cycle following edge N+DB_CYC+2. Latency is DB_CYC+2 cycles.
- Deferred read: one extra cycle.
- Release acceptance: DB_CYC+2 cycles after a stable low input. A new press cannot be accepted before the channel returns to IDLE.
- Counter arithmetic is unsigned `CNT_W` bits with no wrap. The counter saturates at the terminal count and is cleared on every state change.
- Minimum spacing between two events on the same channel: 2·DB_CYC+4 cycles without auto-repeat.

## Configuration
- `FIFO_REQ_AUTOREPEAT_EN` defined:
  - In HELD, a repeat counter runs and emits a further press event every REPEAT_CYC cycles while the button stays held.
  - Each repeated write event recaptures `sw_data`.
  - The repeat counter resets on entering HELD, including from RELEASING.
  - Repeat events follow the same write-priority and deferral rules.
- Not defined: the repeat logic is absent, and exactly one event is emitted per accepted press.

## Test plan
- Clean write press with DB_CYC=4 and `sw_data`=0xA5: `button_wrd` rises at edge 10 → one-cycle `wr_pulse` after edge 16, `wr_data`=0xA5, `rd_pulse` stays 0.
- Bounce: `button_red` toggles 1,0,1,0 every cycle, then is held high → exactly one `rd_pulse`, occurring DB_CYC+2 cycles after the last rising glitch. A glitch during RELEASING produces no extra pulse.
- Simultaneous presses: both buttons rise at the same edge → `wr_pulse` in cycle T, `rd_pulse` in cycle T+1, never overlapping.
- Reset mid-ARMING: `clr` pulsed 2 cycles into debounce with the button still held → all outputs 0 during reset, and a single pulse DB_CYC+2 cycles after `clr` falls.
- `FIFO_REQ_AUTOREPEAT_EN` with REPEAT_CYC=10: write held for 35 cycles after the first pulse → 4 `wr_pulse`s total, spaced 10 cycles apart. The same test without the macro → 1 pulse.
- `sw_data` changes 0x11 → 0x22 between two presses → `wr_data` reads 0x11, then 0x22, and holds between pulses.

Source files
------------

// File: rtl/fifo_req_gen.sv
// fifo_req_gen: debounced one-shot write/read strobes for the push-button FIFO (optional FIFO_REQ_AUTOREPEAT_EN)
module fifo_req_chan #(
  parameter int DB_CYC     = 1000,
  parameter int CNT_W      = 20,
  parameter int REPEAT_CYC = 4000
) (
  input  logic clk,
  input  logic clr,
  input  logic button,
  output logic held,
  output logic ev
);
  typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} state_t;
  localparam logic [CNT_W-1:0] DB_TC = CNT_W'(DB_CYC - 1);
  state_t st;
  logic s1, s2;
  logic [CNT_W-1:0] cnt;
  if (DB_CYC < 2 || REPEAT_CYC < 1) begin : g_bad_param
    $error("fifo_req_chan: DB_CYC must be >= 2 and REPEAT_CYC >= 1");
  end
`ifdef FIFO_REQ_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RP_TC = CNT_W'(REPEAT_CYC - 1);
  logic [CNT_W-1:0] rcnt;
  assign ev = s2 && ((st == ARMING && cnt == DB_TC) || (st == HELD && rcnt == RP_TC));
`else
  assign ev = s2 && st == ARMING && cnt == DB_TC;
`endif
  assign held = st == HELD || st == RELEASING;
  // synchronizer plus debounce FSM; the counter restarts on every state change
  always_ff @(posedge clk) begin
    if (clr) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      st  <= IDLE;
      cnt <= '0;
`ifdef FIFO_REQ_AUTOREPEAT_EN
      rcnt <= '0;
`endif
    end else begin
      s1 <= button;
      s2 <= s1;
      case (st)
        IDLE: if (s2) begin
          st  <= ARMING;
          cnt <= '0;
        end
        ARMING: if (!s2) begin
          st  <= IDLE;
          cnt <= '0;
        end else if (cnt == DB_TC) begin
          st  <= HELD;
          cnt <= '0;
`ifdef FIFO_REQ_AUTOREPEAT_EN
          rcnt <= '0;
`endif
        end else cnt <= cnt + 1'b1;
        HELD: if (!s2) begin
          st  <= RELEASING;
          cnt <= '0;
        end
`ifdef FIFO_REQ_AUTOREPEAT_EN
        else rcnt <= (rcnt == RP_TC) ? '0 : rcnt + 1'b1;
`endif
        RELEASING: if (s2) begin
          st  <= HELD;
          cnt <= '0;
`ifdef FIFO_REQ_AUTOREPEAT_EN
          rcnt <= '0;
`endif
        end else if (cnt == DB_TC) begin
          st  <= IDLE;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

module fifo_req_gen #(
  parameter int B          = 8,
  parameter int DB_CYC     = 1000,
  parameter int CNT_W      = 20,
  parameter int REPEAT_CYC = 4000
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         button_wrd,
  input  logic         button_red,
  input  logic [B-1:0] sw_data,
  output logic         wr_pulse,
  output logic         rd_pulse,
  output logic [B-1:0] wr_data,
  output logic         wr_held,
  output logic         rd_held
);
  logic wr_ev, rd_ev, rd_pend;
  logic [B-1:0] sw_q;
  fifo_req_chan #(.DB_CYC(DB_CYC), .CNT_W(CNT_W), .REPEAT_CYC(REPEAT_CYC)) u_wr (
    .clk(clk), .clr(clr), .button(button_wrd), .held(wr_held), .ev(wr_ev));
  fifo_req_chan #(.DB_CYC(DB_CYC), .CNT_W(CNT_W), .REPEAT_CYC(REPEAT_CYC)) u_rd (
    .clk(clk), .clr(clr), .button(button_red), .held(rd_held), .ev(rd_ev));
  // strobe arbitration: write wins, a colliding read is deferred one cycle
  always_ff @(posedge clk) begin
    if (clr) begin
      sw_q     <= '0;
      wr_data  <= '0;
      wr_pulse <= 1'b0;
      rd_pulse <= 1'b0;
      rd_pend  <= 1'b0;
    end else begin
      sw_q     <= sw_data;
      wr_pulse <= wr_ev;
      rd_pulse <= (rd_ev || rd_pend) && !wr_ev;
      rd_pend  <= (rd_ev || rd_pend) && wr_ev;
      if (wr_ev) wr_data <= sw_q;
    end
  end
endmodule
